// File: rtl/vgg_mem_pkg.sv
// ---------------------------------------------------------------------------
// vgg_mem_pkg
// Shared definitions for the on-chip memory masters of the VGG datapath.
//   rm_state_t   : burst read master FSM state encoding (IDLE/ISSUE/DRAIN)
//   AVL_*        : default Avalon-MM widths of the on-chip weight RAM
// ---------------------------------------------------------------------------
package vgg_mem_pkg;

    typedef logic [1:0] rm_state_t;

    localparam rm_state_t RM_IDLE  = 2'd0;
    localparam rm_state_t RM_ISSUE = 2'd1;
    localparam rm_state_t RM_DRAIN = 2'd2;

    localparam int AVL_DATA_W = 1024;
    localparam int AVL_ADDR_W = 17;
    localparam int AVL_LEN_W  = 8;

endpackage

// File: rtl/rm_fwft_fifo.sv
// ---------------------------------------------------------------------------
// rm_fwft_fifo
// First-word-fall-through return buffer of the burst read master.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i         : write push_data_i this edge
//   push_data_i    : word to store
//   pop_i          : consume the head entry this edge (ignored when empty)
//   head_o         : current head entry (meaningful only when !empty_o)
//   empty_o        : buffer holds no words
//   count_o        : number of stored words (0..DEPTH)
// A push into a full buffer is only taken together with a pop; the owner
// guarantees by credit that this is the only way a full buffer is written.
// ---------------------------------------------------------------------------
module rm_fwft_fifo #(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // When full, the slot being written is the head being popped this edge.
    assign push_ok = push_i && (!full || pop_ok);

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the owner masks the head while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/onchip_burst_read_master.sv
// ---------------------------------------------------------------------------
// onchip_burst_read_master
// Streams bursts of wide words from a fixed-latency Avalon-MM on-chip RAM to
// the PE array.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_valid/ready   : burst command handshake (cmd_addr, cmd_len)
//   addr_read, read_en: Avalon read request, stalled by wait_request
//   byteenable        : constant all ones
//   data_read_input   : Avalon read data, valid READ_LATENCY after accept
//   data_read/valid   : word to the PE array, consumed with data_ready
//   busy              : a burst is in progress
//   done              : one-cycle pulse once the last beat has been consumed
//   dbg_state_o       : current FSM state
// Handshakes: a transfer happens on a clock edge where the producer's valid
// (cmd_valid, read_en, data_valid) and the consumer's ready (cmd_ready,
// !wait_request, data_ready) are both high; a producer holds its payload
// stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module onchip_burst_read_master
    import vgg_mem_pkg::*;
#(
    parameter int DATA_W       = AVL_DATA_W,
    parameter int ADDR_W       = AVL_ADDR_W,
    parameter int LEN_W        = AVL_LEN_W,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_STRIDE  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic [ADDR_W-1:0]   addr_read,
    output logic                read_en,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                wait_request,
    input  logic [DATA_W-1:0]   data_read_input,
    output logic [DATA_W-1:0]   data_read,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                busy,
    output logic                done,
    output rm_state_t           dbg_state_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rm_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
    // Holds cmd_ready low while reset is applied and for the release cycle.
    logic                    live_q;

    logic                    rd_acc;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_W-1:0]       fifo_head;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        credits_used;
    logic                    pop;
    logic                    drained;

    // Reads in the latency pipe plus words buffered: each needs a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vpipe_q[i]);
        end
    end

    assign credits_used = inflight + fifo_count;
    assign read_en      = (state_q == RM_ISSUE) && (rem_q != '0)
                          && (credits_used < CNT_W'(FIFO_DEPTH));
    assign rd_acc       = read_en && !wait_request;
    assign pop          = data_valid && data_ready;
    assign drained      = (vpipe_q == '0) && fifo_empty;

    assign cmd_ready    = (state_q == RM_IDLE) && live_q;
    assign addr_read    = addr_q;
    assign byteenable   = '1;
    assign data_valid   = !fifo_empty;
    assign data_read    = fifo_empty ? '0 : fifo_head;
    assign busy         = (state_q != RM_IDLE);
    assign done         = (state_q == RM_DRAIN) && drained;
    assign dbg_state_o  = state_q;

    always_comb begin
        vpipe_d    = vpipe_q;
        vpipe_d[0] = rd_acc;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            RM_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = (cmd_len == '0) ? RM_DRAIN : RM_ISSUE;
                end
            end
            RM_ISSUE: begin
                if (rd_acc) begin
                    addr_d = addr_q + ADDR_W'(ADDR_STRIDE);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = RM_DRAIN;
                end
            end
            RM_DRAIN: begin
                if (drained) state_d = RM_IDLE;
            end
            default: state_d = RM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RM_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            vpipe_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            vpipe_q <= vpipe_d;
            live_q  <= 1'b1;
        end
    end

    rm_fwft_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (vpipe_q[READ_LATENCY-1]),
        .push_data_i (data_read_input),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_onchip_burst_read_master.sv
// ---------------------------------------------------------------------------
// tb_onchip_burst_read_master
// Directed bench for the burst read master with a fixed-latency RAM model
// and expected-address / expected-data queues.
// ---------------------------------------------------------------------------
module tb_onchip_burst_read_master;
    import vgg_mem_pkg::*;

    localparam int DW = 1024;
    localparam int AW = 17;
    localparam int LW = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic [AW-1:0]   addr_read;
    logic            read_en;
    logic [DW/8-1:0] byteenable;
    logic            wait_request;
    logic [DW-1:0]   data_read_input;
    logic [DW-1:0]   data_read;
    logic            data_valid;
    logic            data_ready;
    logic            busy;
    logic            done;
    rm_state_t       dbg_state;

    onchip_burst_read_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .addr_read       (addr_read),
        .read_en         (read_en),
        .byteenable      (byteenable),
        .wait_request    (wait_request),
        .data_read_input (data_read_input),
        .data_read       (data_read),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .busy            (busy),
        .done            (done),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model (READ_LATENCY = 2) ----------------
    function automatic logic [DW-1:0] w_of(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = {a, 15'(i)} ^ 32'h3C5A_0F96;
        end
        return w;
    endfunction

    logic          rp_v [2];
    logic [AW-1:0] rp_a [2];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_v[0] <= 1'b0;
            rp_v[1] <= 1'b0;
        end else begin
            rp_v[0] <= read_en && !wait_request;
            rp_a[0] <= addr_read;
            rp_v[1] <= rp_v[0];
            rp_a[1] <= rp_a[0];
        end
    end
    always @* data_read_input = rp_v[1] ? w_of(rp_a[1]) : {32{32'hDEAD_BEEF}};

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor (mid-cycle sampling) ----------------
    bit            mon_en = 1'b0;
    bit            hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    int            issued, outst, peak, rd_en_cnt, done_cnt;
    int            acc_cyc, first_rd_cyc, last_rd_cyc, first_val_cyc, last_pop_cyc;
    int            cur_len;

    initial begin
        issued = 0; outst = 0; peak = 0; rd_en_cnt = 0; done_cnt = 0;
        acc_cyc = 0; first_rd_cyc = 0; last_rd_cyc = 0; first_val_cyc = -1;
        last_pop_cyc = 0; cur_len = 0;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_pend) begin
                chk("hold_read_en", 64'(read_en), 64'd1);
                chk("hold_addr", 64'(addr_read), 64'(hold_addr));
                hold_pend = 1'b0;
            end
            if (read_en && wait_request) begin
                hold_pend = 1'b1;
                hold_addr = addr_read;
            end
            if (read_en) rd_en_cnt++;
            if (read_en && !wait_request) begin
                logic [AW-1:0] ea;
                ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                chk("read_addr", 64'(addr_read), 64'(ea));
                if (issued == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                issued++;
                outst++;
                if (outst > peak) peak = outst;
                chk("credit_limit", 64'(outst <= DEPTH), 64'd1);
            end
            if (data_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (data_valid && data_ready) begin
                logic [DW-1:0] ew;
                ew = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                chk_w("pe_data", data_read, ew);
                outst--;
                last_pop_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (done) begin
                done_cnt++;
                chk("done_timing", 64'(cyc),
                    64'((cur_len == 0) ? acc_cyc + 1 : last_pop_cyc + 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit stall_toggle = 1'b0;
    int ready_hold = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        wait_request = stall_toggle ? ~wait_request : 1'b0;
        if (ready_hold > 0) begin
            data_ready = 1'b0;
            ready_hold--;
        end else begin
            data_ready = 1'b1;
        end
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input int len, input bit wait_done);
        int n;
        int d0;
        logic [AW-1:0] ai;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        issued = 0; peak = 0; first_val_cyc = -1; cur_len = len;
        d0 = done_cnt;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            ai = a + AW'(i);
            exp_addr_q.push_back(ai);
            exp_q.push_back(w_of(ai));
        end
        tick();
        cmd_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            while (done_cnt == d0 && n < 500) begin
                tick();
                n++;
            end
            chk("done_seen", 64'(done_cnt), 64'(d0 + 1));
            chk("queues_empty", 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
            chk("busy_after", 64'(busy), 64'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int d0;
        int rd0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        wait_request = 1'b0;
        data_ready = 1'b1;
        #2;
        chk("rst_read_en", 64'(read_en), 64'd0);
        chk("rst_addr", 64'(addr_read), 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk_w("rst_data_read", data_read, '0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(RM_IDLE));
        chk_w("byteenable", DW'(byteenable), DW'({(DW/8){1'b1}}));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // 1: basic 4-beat burst, no stalls
        run_cmd(17'h00100, 4, 1'b1);
        chk("t1_first_read", 64'(first_rd_cyc), 64'(acc_cyc + 1));
        chk("t1_back_to_back", 64'(last_rd_cyc - first_rd_cyc), 64'd3);
        chk("t1_first_valid", 64'(first_val_cyc), 64'(acc_cyc + 4));

        // 2: wait_request every other cycle
        stall_toggle = 1'b1;
        run_cmd(17'h00200, 16, 1'b1);
        stall_toggle = 1'b0;
        wait_request = 1'b0;
        chk("t2_issued", 64'(issued), 64'd16);

        // 3: PE backpressure for 30 cycles
        ready_hold = 30;
        run_cmd(17'h00300, 20, 1'b1);
        chk("t3_peak_outstanding", 64'(peak), 64'(DEPTH));
        chk("t3_issued", 64'(issued), 64'd20);

        // 4: address wrap
        run_cmd(17'h1FFFE, 4, 1'b1);
        chk("t4_issued", 64'(issued), 64'd4);

        // 5: zero-length command
        rd0 = rd_en_cnt;
        run_cmd(17'h00055, 0, 1'b1);
        chk("t5_no_read_en", 64'(rd_en_cnt), 64'(rd0));

        // 6: reset in the middle of an 8-beat burst
        run_cmd(17'h00040, 8, 1'b0);
        n = 0;
        while (issued < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_issued_before_rst", 64'(issued), 64'd3);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_read_en", 64'(read_en), 64'd0);
        chk("t6_addr", 64'(addr_read), 64'd0);
        chk("t6_data_valid", 64'(data_valid), 64'd0);
        chk_w("t6_data_read", data_read, '0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_cmd_ready", 64'(cmd_ready), 64'd0);
        exp_q.delete();
        exp_addr_q.delete();
        outst = 0;
        hold_pend = 1'b0;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (4) tick();
        chk("t6_no_done_after_rst", 64'(done_cnt), 64'(d0));
        chk("t6_state_idle", 64'(dbg_state), 64'(RM_IDLE));
        run_cmd(17'h01234, 2, 1'b1);
        chk("t6_post_issued", 64'(issued), 64'd2);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
